// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - memory-mapped down-counting timer with prescaler, auto-reload and level irq
// Optional feature macro: TIMER_PWM_EN (adds the CMP register and a registered pwm_out).
// Register window (word offsets): 0 CTRL, 1 PRESCALE, 2 LOAD, 3 COUNT, 4 STATUS, 5 CMP, 6-7 reserved.
module bus_timer #(
   parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
   parameter int          PRESCALE_WIDTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   output logic        ready,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic [31:0] rdata,
   output logic        irq,
   output logic        pwm_out
);

   // control and timer state
   logic                      en;
   logic                      auto_reload;
   logic                      irq_en;
   logic [PRESCALE_WIDTH-1:0] prescale;
   logic [PRESCALE_WIDTH-1:0] pcnt;
   logic [31:0]               load;
   logic [31:0]               count;
   logic                      flag;

   // bus decode; hold stays set while the CPU keeps valid high after its acknowledge
   logic        sel;
   logic        hold;
   logic        access;
   logic        wr;
   logic [2:0]  offset;
   logic [31:0] bmask;
   logic [31:0] rd_val;
   logic [31:0] prescale_ext;
   logic        tick;
   logic        expire;
   logic        wr_ctrl;
   logic        wr_prescale;
   logic        wr_load;
   logic        wr_count;
   logic        wr_status;
   logic        unused_addr;

   assign sel          = valid && (addr[31:5] == BASE_ADDR[31:5]);
   assign access       = sel && !ready && !hold;
   assign wr           = access && (wstrb != 4'b0000);
   assign offset       = addr[4:2];
   assign bmask        = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
   assign prescale_ext = 32'(prescale);
   assign unused_addr  = &{1'b0, addr[1:0]};

   assign wr_ctrl      = wr && (offset == 3'd0);
   assign wr_prescale  = wr && (offset == 3'd1);
   assign wr_load      = wr && (offset == 3'd2);
   assign wr_count     = wr && (offset == 3'd3);
   assign wr_status    = wr && (offset == 3'd4);

   // a tick fires on the clock where the prescaler reaches its terminal value
   assign tick   = en && (pcnt == prescale);
   assign expire = tick && (count == 32'd0);

`ifdef TIMER_PWM_EN
   logic [31:0] cmp;
   logic        wr_cmp;
   logic        pwm_q;

   assign wr_cmp  = wr && (offset == 3'd5);
   assign pwm_out = pwm_q;

   // compare register, byte-masked
   always_ff @(posedge clk) begin
      if (reset) cmp <= 32'd0;
      else if (wr_cmp) cmp <= (cmp & ~bmask) | (wdata & bmask);
   end

   // pwm is high while the running counter sits below the compare value
   always_ff @(posedge clk) begin
      if (reset) pwm_q <= 1'b0;
      else       pwm_q <= en && (count < cmp);
   end
`else
   assign pwm_out = 1'b0;
`endif

   // register read mux; unimplemented offsets read zero
   always_comb begin
      rd_val = 32'd0;
      case (offset)
         3'd0: rd_val = {29'd0, irq_en, auto_reload, en};
         3'd1: rd_val = prescale_ext;
         3'd2: rd_val = load;
         3'd3: rd_val = count;
         3'd4: rd_val = {31'd0, flag};
`ifdef TIMER_PWM_EN
         3'd5: rd_val = cmp;
`endif
         default: rd_val = 32'd0;
      endcase
   end

   // one-cycle acknowledge with registered read data, suppressed until valid drops
   always_ff @(posedge clk) begin
      if (reset) begin
         ready <= 1'b0;
         rdata <= 32'd0;
         hold  <= 1'b0;
      end else begin
         ready <= access;
         rdata <= access ? rd_val : 32'd0;
         hold  <= valid && (hold || ready);
      end
   end

   // CTRL: a one-shot expiry clears EN, but a CPU write in the same cycle wins
   always_ff @(posedge clk) begin
      if (reset) begin
         en          <= 1'b0;
         auto_reload <= 1'b0;
         irq_en      <= 1'b0;
      end else begin
         if (expire && !auto_reload) en <= 1'b0;
         if (wr_ctrl && wstrb[0]) begin
            en          <= wdata[0];
            auto_reload <= wdata[1];
            irq_en      <= wdata[2];
         end
      end
   end

   // PRESCALE and LOAD registers, byte-masked
   always_ff @(posedge clk) begin
      if (reset) begin
         prescale <= '0;
         load     <= 32'd0;
      end else begin
         if (wr_prescale) prescale <= PRESCALE_WIDTH'((prescale_ext & ~bmask) | (wdata & bmask));
         if (wr_load)     load     <= (load & ~bmask) | (wdata & bmask);
      end
   end

   // prescaler counter: idle at zero while disabled, restarted by a PRESCALE write
   always_ff @(posedge clk) begin
      if (reset || !en || wr_prescale) pcnt <= '0;
      else if (tick)                   pcnt <= '0;
      else                             pcnt <= pcnt + 1'b1;
   end

   // down-counter: a CPU write takes priority over the tick's decrement or reload
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 32'd0;
      end else if (wr_count) begin
         count <= (count & ~bmask) | (wdata & bmask);
      end else if (tick) begin
         if (count != 32'd0)  count <= count - 32'd1;
         else if (auto_reload) count <= load;
      end
   end

   // expiry flag: set on expiry, write-1-to-clear, set beats clear
   always_ff @(posedge clk) begin
      if (reset)                                      flag <= 1'b0;
      else if (expire)                                flag <= 1'b1;
      else if (wr_status && wstrb[0] && wdata[0])     flag <= 1'b0;
   end

   // level interrupt, one clock behind the flag
   always_ff @(posedge clk) begin
      if (reset) irq <= 1'b0;
      else       irq <= flag && irq_en;
   end

endmodule

// File: tb/tb_bus_timer.sv
// tb/tb_bus_timer.sv - self-checking bench for bus_timer with a register-array reference model
module tb_bus_timer;

   localparam logic [31:0] BASE = 32'h0300_0000;
`ifdef TIMER_PWM_EN
   localparam bit PWM = 1'b1;
`else
   localparam bit PWM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid = 1'b0;
   logic        ready;
   logic [31:0] addr = BASE;
   logic [31:0] wdata = 32'd0;
   logic [3:0]  wstrb = 4'd0;
   logic [31:0] rdata;
   logic        irq;
   logic        pwm_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit cmp_on = 1'b0;

   bus_timer #(.BASE_ADDR(BASE), .PRESCALE_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .valid(valid), .ready(ready), .addr(addr),
      .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .irq(irq), .pwm_out(pwm_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: registers as an array indexed by word offset
   // 0 CTRL, 1 PRESCALE, 2 LOAD, 3 COUNT, 4 STATUS(flag), 5 CMP, 6/7 reserved
   logic [31:0] mreg [8];
   logic [31:0] nreg [8];
   logic [31:0] impl [8];
   logic [15:0] mpcnt = 16'd0;
   logic [15:0] npcnt;
   logic        m_ready = 1'b0, m_irq = 1'b0, m_pwm = 1'b0, m_hold = 1'b0;
   logic [31:0] m_rdata = 32'd0;
   logic        m_acc, m_wr, m_tick, m_en, m_auto;
   logic [2:0]  m_off;
   logic [31:0] m_mask;

   initial begin
      for (int i = 0; i < 8; i++) mreg[i] = 32'd0;
      impl[0] = 32'h7;         impl[1] = 32'h0000_FFFF;
      impl[2] = 32'hFFFF_FFFF; impl[3] = 32'hFFFF_FFFF;
      impl[4] = 32'h1;         impl[5] = PWM ? 32'hFFFF_FFFF : 32'h0;
      impl[6] = 32'h0;         impl[7] = 32'h0;
   end

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) mreg[i] = 32'd0;
         mpcnt = 16'd0; m_ready = 1'b0; m_rdata = 32'd0;
         m_irq = 1'b0; m_pwm = 1'b0; m_hold = 1'b0;
      end else begin
         m_en   = mreg[0][0];
         m_auto = mreg[0][1];
         m_off  = addr[4:2];
         m_acc  = valid && (addr[31:5] == BASE[31:5]) && !m_ready && !m_hold;
         m_wr   = m_acc && (wstrb != 4'd0);
         m_mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}} & impl[m_off];
         m_tick = m_en && (mpcnt == mreg[1][15:0]);
         for (int i = 0; i < 8; i++) nreg[i] = mreg[i];
         npcnt = (!m_en || m_tick) ? 16'd0 : mpcnt + 16'd1;
         // timer consequences of this clock
         if (m_tick) begin
            if (mreg[3] > 0) nreg[3] = mreg[3] - 1;
            else begin
               nreg[4] = 32'd1;
               if (m_auto) nreg[3] = mreg[2];
               else        nreg[0] = mreg[0] & 32'h6;
            end
         end
         // CPU write applied on top; it overrides the timer except flag set
         if (m_wr) begin
            if (m_off == 3'd4) begin
               if (wstrb[0] && wdata[0] && !(m_tick && mreg[3] == 0)) nreg[4] = 32'd0;
            end else if (m_off == 3'd3) begin
               nreg[3] = (mreg[3] & ~m_mask) | (wdata & m_mask);
            end else begin
               nreg[m_off] = (nreg[m_off] & ~m_mask) | (wdata & m_mask);
               if (m_off == 3'd1) npcnt = 16'd0;
            end
         end
         m_irq   = mreg[4][0] && mreg[0][2];
         m_pwm   = PWM && mreg[0][0] && (mreg[3] < mreg[5]);
         m_rdata = m_acc ? mreg[m_off] : 32'd0;
         m_hold  = valid && (m_hold || m_ready);
         m_ready = m_acc;
         for (int i = 0; i < 8; i++) mreg[i] = nreg[i];
         mpcnt = npcnt;
      end
   end

   // continuous comparison away from the active edge
   always @(negedge clk) begin
      if (cmp_on) begin
         check("ready", {31'd0, ready}, {31'd0, m_ready});
         check("rdata", rdata, m_rdata);
         check("irq", {31'd0, irq}, {31'd0, m_irq});
         check("pwm_out", {31'd0, pwm_out}, {31'd0, m_pwm});
      end
   end

   // ---------------- bus helpers (entered and left at posedge + 1)
   task automatic bus(input logic w, input logic [2:0] off, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rv);
      int n;
      valid = 1'b1;
      addr  = BASE | {27'd0, off, 2'b00};
      wdata = w ? d : 32'd0;
      wstrb = w ? s : 4'd0;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!ready && n < 8);
      check("bus_latency", n, 1);
      rv    = rdata;
      valid = 1'b0;
      wstrb = 4'd0;
      @(posedge clk); #1;
   endtask

   task automatic bus_wr(input logic [2:0] off, input logic [31:0] d);
      logic [31:0] dummy;
      bus(1'b1, off, d, 4'hF, dummy);
   endtask

   task automatic bus_rd(input logic [2:0] off, output logic [31:0] rv);
      bus(1'b0, off, 32'd0, 4'd0, rv);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic wait_irq(output int n);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!irq && n < 200);
   endtask

   logic [31:0] v;
   int          n, rcnt, first, t1, t2, hi;

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_pwm", {31'd0, pwm_out}, 32'd0);
      reset  = 1'b0;
      cmp_on = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus_rd(3'(i), v);
         check("rst_reg", v, 32'd0);
      end

      // held valid: exactly one acknowledge, one cycle after valid
      valid = 1'b1; addr = BASE | 32'h8; wdata = 32'd5; wstrb = 4'hF;
      rcnt = 0; first = 0;
      for (int k = 1; k <= 5; k++) begin
         if (k == 4) begin valid = 1'b0; wstrb = 4'd0; end
         @(posedge clk); #1;
         if (ready) begin rcnt++; if (first == 0) first = k; end
      end
      check("hold_ready_count", rcnt, 1);
      check("hold_ready_latency", first, 1);
      bus_rd(3'd2, v);  check("load_readback", v, 32'd5);
      bus_rd(3'd7, v);  check("reserved_1c", v, 32'd0);

      // byte strobes
      bus_wr(3'd2, 32'd0);
      bus(1'b1, 3'd2, 32'hAABB_CCDD, 4'b0101, v);
      bus_rd(3'd2, v);  check("strobe_load", v, 32'h00BB_00DD);
      check("model_strobe_load", mreg[2], 32'h00BB_00DD);

      // one-shot
      bus_wr(3'd1, 32'd0);
      bus_wr(3'd3, 32'd3);
      bus_wr(3'd0, 32'd1);
      repeat (8) @(posedge clk);
      #1;
      bus_rd(3'd0, v);  check("oneshot_ctrl", v, 32'd0);
      bus_rd(3'd3, v);  check("oneshot_count", v, 32'd0);
      bus_rd(3'd4, v);  check("oneshot_flag", v, 32'd1);
      check("oneshot_irq", {31'd0, irq}, 32'd0);
      bus_wr(3'd4, 32'd1);
      bus_wr(3'd3, 32'd3);
      bus_wr(3'd0, 32'd5);
      wait_irq(n);      check("oneshot_irq_delay", n, 4);
      bus_wr(3'd0, 32'd0);
      check("irqen_off_irq", {31'd0, irq}, 32'd0);
      bus_rd(3'd4, v);  check("irqen_off_flag", v, 32'd1);
      bus_wr(3'd4, 32'd1);

      // auto-reload period and irq clear/reassert
      bus_wr(3'd1, 32'd2);
      bus_wr(3'd2, 32'd4);
      bus_wr(3'd3, 32'd4);
      bus_wr(3'd0, 32'd7);
      wait_irq(n);  t1 = cyc;
      bus_wr(3'd4, 32'd1);
      check("auto_irq_cleared", {31'd0, irq}, 32'd0);
      wait_irq(n);  t2 = cyc;
      check("auto_period", t2 - t1, 15);
      bus_wr(3'd0, 32'd0);
      bus_wr(3'd4, 32'd1);

      // COUNT write in a tick cycle wins
      bus_wr(3'd1, 32'd1);
      bus_wr(3'd3, 32'd100);
      bus_wr(3'd0, 32'd1);
      bus_wr(3'd3, 32'd10);
      bus_rd(3'd3, v);  check("count_write_wins", v, 32'd10);
      bus_wr(3'd0, 32'd0);

      // STATUS clear in the expiry cycle loses
      bus_wr(3'd1, 32'd0);
      bus_wr(3'd4, 32'd1);
      bus_wr(3'd3, 32'd1);
      bus_wr(3'd0, 32'd1);
      bus_wr(3'd4, 32'd1);
      bus_rd(3'd4, v);  check("flag_set_wins", v, 32'd1);
      check("model_flag_set_wins", mreg[4], 32'd1);

      // randomized traffic checked continuously against the model
      for (int t = 0; t < 500; t++) begin
         int kind;
         logic [2:0] off;
         logic [31:0] d;
         logic [3:0] s;
         kind = $urandom_range(0, 99);
         off  = 3'($urandom_range(0, 7));
         if (kind < 2) begin
            pulse_reset();
         end else if (kind < 4) begin
            valid = 1'b1; addr = BASE | {27'd0, off, 2'b00}; wstrb = 4'd0;
            @(posedge clk); #1;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0; valid = 1'b0;
         end else begin
            case ($urandom_range(0, 3))
               0:       d = $urandom;
               1:       d = 32'($urandom_range(0, 7));
               default: d = 32'($urandom_range(0, 12));
            endcase
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
            bus($urandom_range(0, 2) != 0, off, d, s, v);
         end
         repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
      end

`ifdef TIMER_PWM_EN
      // pwm duty: CMP=3 over a 10-tick reload cycle
      pulse_reset();
      bus_wr(3'd2, 32'd9);
      bus_wr(3'd3, 32'd9);
      bus_wr(3'd5, 32'd3);
      bus_wr(3'd0, 32'd3);
      repeat (5) @(posedge clk);
      #1;
      hi = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (pwm_out) hi++;
      end
      check("pwm_duty", hi, 30);
`endif

      // reset in the middle of counting
      bus_wr(3'd1, 32'd1);
      bus_wr(3'd2, 32'd9);
      bus_wr(3'd3, 32'd9);
      bus_wr(3'd0, 32'd7);
      repeat (25) @(posedge clk);
      #1;
      pulse_reset();
      check("midrst_ready", {31'd0, ready}, 32'd0);
      check("midrst_irq", {31'd0, irq}, 32'd0);
      check("midrst_pwm", {31'd0, pwm_out}, 32'd0);
      check("model_midrst_count", mreg[3], 32'd0);
      for (int i = 0; i < 8; i++) begin
         bus_rd(3'(i), v);
         check("midrst_reg", v, 32'd0);
      end

      cmp_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
